arbitro_temporizador: RTL and testbench

Shares one delay timer between N_REQ requesters on the 12 MHz board clock. Each requester raises a request with a duration in ticks (default 100 µs). The block grants the timer to one requester at a time in round-robin order, times the interval exactly and pulses that requester's done line. It sits beside the existing timer block and serves blocks that need non-overlapping timed waits: debounce, LED heartbeat phases and protocol timeouts.

---
 rtl/arbitro_temporizador_pkg.sv | 47 ++++
 rtl/arbitro_temporizador_prescaler_tick.sv | 32 +++
 rtl/arbitro_temporizador.sv | 146 ++++++++++++++
 tb/tb_arbitro_temporizador.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_temporizador_pkg.sv
// Shared definitions for the timer arbiter: FSM states, prescaler divider
// computation, board timing defaults and the round-robin selector.
package arbitro_temporizador_pkg;

    // Board clock and default tick rate, shared with the other timing blocks.
    localparam int unsigned DEF_CLK_HZ  = 12_000_000;
    localparam int unsigned DEF_TICK_HZ = 10_000;

    // Widest requester vector the selector supports; the index fits in 3 bits.
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Clock cycles per tick. The caller guarantees an exact integer >= 2.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // First set request at or above ptr, wrapping modulo n_req.
    function automatic rr_pick_t rr_select(input logic [MAX_REQ-1:0] req,
                                           input logic [IDX_W-1:0]   ptr,
                                           input int unsigned        n_req);
        rr_pick_t    pick;
        int unsigned cand;
        pick = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            cand = ({29'd0, ptr} + k) % n_req;
            if ((k < n_req) && !pick.valid && req[cand[IDX_W-1:0]]) begin
                pick.valid = 1'b1;
                pick.idx   = cand[IDX_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arbitro_temporizador_prescaler_tick.sv
// Free-running divide-by-DIV tick generator with a synchronous clear, so an
// owner of the tick can align its phase to an event (e.g. a timer grant).
module prescaler_tick #(
    parameter int unsigned DIV = 10
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    // Count 0..DIV-1 and wrap; a clear restarts the phase at zero.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/arbitro_temporizador.sv
// Round-robin arbiter sharing one tick-based delay timer among N_REQ
// requesters. The owner gets gnt while its interval runs and a one-cycle
// done pulse when it expires.
// Optional feature: define ARB_TEMP_CANCEL_EN to let the owner abort a
// running interval by dropping its req (no done pulse is issued).
module arbitro_temporizador
    import arbitro_temporizador_pkg::*;
#(
    parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
    parameter int unsigned TICK_HZ = DEF_TICK_HZ,
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DUR_W   = 16
) (
    input  logic                   clock_in,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DUR_W-1:0] dur,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   tick
);

    localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] next_ptr;
    logic             presc_clr;
    logic             tick_int;
    logic             cancel_hit;
    logic [MAX_REQ-1:0] req_ext;
    logic [DUR_W-1:0]   dur_arr [MAX_REQ];
    rr_pick_t           pick;

    // Shared tick; its phase restarts on each grant so intervals are exact.
    prescaler_tick #(
        .DIV (DIV)
    ) u_prescaler (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .clr      (presc_clr),
        .tick     (tick_int)
    );

    // Split the flat duration bus per requester; unused slots read as zero.
    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_dur
        if (gi < N_REQ) begin : g_used
            assign dur_arr[gi] = dur[gi*DUR_W +: DUR_W];
        end else begin : g_unused
            assign dur_arr[gi] = '0;
        end
    end

    // Widen req to the selector's fixed width.
    always_comb begin
        req_ext = '0;
        req_ext[N_REQ-1:0] = req;
    end

    assign pick     = rr_select(req_ext, ptr_q, N_REQ);
    assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

`ifdef ARB_TEMP_CANCEL_EN
    assign cancel_hit = (state_q == RUN) && !req_ext[owner_q];
`else
    assign cancel_hit = 1'b0;
`endif

    // Next-state and next-output logic for the arbiter FSM.
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        presc_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick.valid) begin
                    owner_d   = pick.idx;
                    gnt_d     = N_REQ'(1) << pick.idx;
                    cnt_d     = dur_arr[pick.idx];
                    presc_clr = 1'b1;
                    // A zero duration still holds gnt for one cycle; the RUN
                    // state sees cnt==0 and finishes on the very next edge.
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (cancel_hit) begin
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end else if ((cnt_q == '0) || (tick_int && (cnt_q == DUR_W'(1)))) begin
                    gnt_d   = '0;
                    done_d  = gnt_q;
                    state_d = DONE;
                end else if (tick_int) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                ptr_d   = next_ptr;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);
    assign tick = tick_int;

endmodule

// File: tb/tb_arbitro_temporizador.sv
// Directed self-checking bench for arbitro_temporizador (DIV = 10, 4 requesters).
module tb_arbitro_temporizador;

    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int DIV     = 10;
    localparam int N_REQ   = 4;
    localparam int DUR_W   = 16;

    logic                   clock_in = 1'b0;
    logic                   reset_n  = 1'b0;
    logic [N_REQ-1:0]       req      = '0;
    logic [N_REQ*DUR_W-1:0] dur      = '0;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic                   tick;

    int checks   = 0;
    int failures = 0;

    arbitro_temporizador #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .N_REQ   (N_REQ),
        .DUR_W   (DUR_W)
    ) dut (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .req      (req),
        .dur      (dur),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .tick     (tick)
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    task automatic set_dur(input int idx, input int value);
        dur[idx*DUR_W +: DUR_W] = DUR_W'(value);
    endtask

    task automatic do_reset();
        req     = '0;
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    // Expects a grant on the next edge, done exactly d*DIV edges later, then idle.
    task automatic expect_service(input int idx, input int d, input bit keep, input string name);
        logic [N_REQ-1:0] oh;
        logic [DUR_W-1:0] saved;
        oh    = 4'b0001 << idx;
        saved = dur[idx*DUR_W +: DUR_W];
        step();
        checks++;
        if ({gnt, done, busy} !== {oh, 4'b0000, 1'b1}) begin
            failures++;
            $display("FAIL %s grant: gnt=%b done=%b busy=%b, expected gnt=%b done=0000 busy=1",
                     name, gnt, done, busy, oh);
        end
        dur[idx*DUR_W +: DUR_W] = saved ^ 16'h00a5;
        if (d > 0) begin
            step(d * DIV - 1);
            checks++;
            if ({gnt, done, busy} !== {oh, 4'b0000, 1'b1}) begin
                failures++;
                $display("FAIL %s hold: gnt=%b done=%b busy=%b, expected gnt=%b done=0000 busy=1",
                         name, gnt, done, busy, oh);
            end
        end
        step();
        checks++;
        if ({gnt, done, busy} !== {4'b0000, oh, 1'b1}) begin
            failures++;
            $display("FAIL %s done: gnt=%b done=%b busy=%b, expected gnt=0000 done=%b busy=1",
                     name, gnt, done, busy, oh);
        end
        dur[idx*DUR_W +: DUR_W] = saved;
        if (!keep) req[idx] = 1'b0;
        step();
        checks++;
        if ({gnt, done, busy} !== {4'b0000, 4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL %s idle: gnt=%b done=%b busy=%b, expected all zero",
                     name, gnt, done, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = '0;
        step(2);
        checks++;
        if ({gnt, done, busy, tick} !== 10'b0) begin
            failures++;
            $display("FAIL reset_state: gnt=%b done=%b busy=%b tick=%b, expected all zero",
                     gnt, done, busy, tick);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_prescaler();
        bit exp_tick;
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            step();
            exp_tick = ((k % DIV) == DIV - 1);
            checks++;
            if (tick !== exp_tick) begin
                failures++;
                $display("FAIL prescaler_tick k=%0d: tick=%b expected %b", k, tick, exp_tick);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        set_dur(2, 3);
        req = 4'b0100;
        expect_service(2, 3, 1'b0, "single");
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_dur(i, 1);
        req = 4'b1111;
        for (int i = 0; i < N_REQ; i++) expect_service(i, 1, 1'b0, $sformatf("contention%0d", i));
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_dur(i, 1);
        req = 4'b0010;
        expect_service(1, 1, 1'b0, "fair_first");
        req = 4'b0011;
        expect_service(0, 1, 1'b0, "fair_zero");
        expect_service(1, 1, 1'b0, "fair_one");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_dur(i, 1);
        req = 4'b0100;
        expect_service(2, 1, 1'b0, "b2b_setup");
        req = 4'b1111;
        expect_service(3, 1, 1'b1, "b2b_3");
        expect_service(0, 1, 1'b1, "b2b_0");
        expect_service(1, 1, 1'b1, "b2b_1");
        expect_service(2, 1, 1'b1, "b2b_2");
        expect_service(3, 1, 1'b1, "b2b_3again");
        req = '0;
        step();
        checks++;
        if ({gnt, busy} !== 5'b0) begin
            failures++;
            $display("FAIL b2b_release: gnt=%b busy=%b, expected 0", gnt, busy);
        end
    endtask

    task automatic test_zero_and_wrap();
        do_reset();
        set_dur(3, 0);
        req = 4'b1000;
        expect_service(3, 0, 1'b0, "zero_dur");
        set_dur(0, 1);
        set_dur(3, 1);
        req = 4'b1001;
        expect_service(0, 1, 1'b0, "wrap_0");
        expect_service(3, 1, 1'b0, "wrap_3");
    endtask

    task automatic test_reset_mid_run();
        bit seen_done;
        do_reset();
        set_dur(0, 5);
        req = 4'b0001;
        step();
        checks++;
        if ({gnt, busy} !== {4'b0001, 1'b1}) begin
            failures++;
            $display("FAIL midrst_grant: gnt=%b busy=%b, expected gnt=0001 busy=1", gnt, busy);
        end
        step(2 * DIV);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt, done, busy, tick} !== 10'b0) begin
            failures++;
            $display("FAIL midrst_async: gnt=%b done=%b busy=%b tick=%b, expected all zero",
                     gnt, done, busy, tick);
        end
        req = '0;
        step();
        reset_n   = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 6 * DIV; k++) begin
            step();
            if (done !== 4'b0000 || busy !== 1'b0) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            failures++;
            $display("FAIL midrst_quiet: activity seen after reset, expected none");
        end
        set_dur(1, 2);
        req = 4'b0010;
        expect_service(1, 2, 1'b0, "midrst_fresh");
    endtask

    task automatic test_cancel();
        do_reset();
        set_dur(1, 5);
        req = 4'b0010;
        step();
        checks++;
        if ({gnt, busy} !== {4'b0010, 1'b1}) begin
            failures++;
            $display("FAIL cancel_grant: gnt=%b busy=%b, expected gnt=0010 busy=1", gnt, busy);
        end
        step(14);
        req = 4'b0000;
        step();
`ifdef ARB_TEMP_CANCEL_EN
        begin
            bit seen_done;
            checks++;
            if ({gnt, done, busy} !== 9'b0) begin
                failures++;
                $display("FAIL cancel_abort: gnt=%b done=%b busy=%b, expected all zero",
                         gnt, done, busy);
            end
            seen_done = 1'b0;
            for (int k = 0; k < 40; k++) begin
                step();
                if (done !== 4'b0000) seen_done = 1'b1;
            end
            checks++;
            if (seen_done) begin
                failures++;
                $display("FAIL cancel_nodone: done pulse seen after abort, expected none");
            end
        end
`else
        checks++;
        if ({gnt, done, busy} !== {4'b0010, 4'b0000, 1'b1}) begin
            failures++;
            $display("FAIL nocancel_hold15: gnt=%b done=%b busy=%b, expected gnt=0010 done=0000 busy=1",
                     gnt, done, busy);
        end
        step(34);
        checks++;
        if ({gnt, done, busy} !== {4'b0010, 4'b0000, 1'b1}) begin
            failures++;
            $display("FAIL nocancel_hold49: gnt=%b done=%b busy=%b, expected gnt=0010 done=0000 busy=1",
                     gnt, done, busy);
        end
        step();
        checks++;
        if ({gnt, done, busy} !== {4'b0000, 4'b0010, 1'b1}) begin
            failures++;
            $display("FAIL nocancel_done50: gnt=%b done=%b busy=%b, expected gnt=0000 done=0010 busy=1",
                     gnt, done, busy);
        end
        step();
        checks++;
        if ({gnt, done, busy} !== 9'b0) begin
            failures++;
            $display("FAIL nocancel_idle: gnt=%b done=%b busy=%b, expected all zero",
                     gnt, done, busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_single();
        test_contention();
        test_fairness();
        test_back_to_back();
        test_zero_and_wrap();
        test_reset_mid_run();
        test_cancel();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
